board_status_arbiter: RTL and testbench

//  Owns the 8x8 x 4-bit cell-status store and arbitrates its single access slot per cycle.

---
 rtl/board_status_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_board_status_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_status_arbiter.sv
// Cell-status store for the board grid with one access slot per cycle shared by the
// display path (cached per cell), game writes and game reads, plus a board-wide CLEAR sweep.
module board_status_arbiter #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int STAT_W = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        disp_en,
    input  logic [$clog2(GRID_W)-1:0]   disp_cell_x,
    input  logic [$clog2(GRID_H)-1:0]   disp_cell_y,
    output logic [STAT_W-1:0]           disp_status,
    input  logic                        wr_req,
    input  logic [$clog2(GRID_W)-1:0]   wr_x,
    input  logic [$clog2(GRID_H)-1:0]   wr_y,
    input  logic [STAT_W-1:0]           wr_data,
    output logic                        wr_ack,
    input  logic                        rd_req,
    input  logic [$clog2(GRID_W)-1:0]   rd_x,
    input  logic [$clog2(GRID_H)-1:0]   rd_y,
    output logic [STAT_W-1:0]           rd_data,
    output logic                        rd_ack,
    input  logic                        clear_req,
    output logic                        busy
);
    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);
    localparam int DEPTH = GRID_W * GRID_H;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_e;
    typedef enum logic {RR_WRITE = 1'b0, RR_READ = 1'b1} rr_e;

    function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] y, input logic [XW-1:0] x);
        cell_addr = AW'(y) * AW'(GRID_W) + AW'(x);
    endfunction

    logic [STAT_W-1:0] store_q [DEPTH];

    state_e            state_q, state_d;
    rr_e               rr_q, rr_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              cache_valid_q, cache_valid_d;
    logic [AW-1:0]     cache_addr_q, cache_addr_d;
    logic [STAT_W-1:0] cache_data_q, cache_data_d;
    logic [STAT_W-1:0] disp_status_q, disp_status_d;
    logic [STAT_W-1:0] rd_data_q, rd_data_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic              busy_q, busy_d;

    logic [AW-1:0]     disp_addr_s, wr_addr_s, rd_addr_s;
    logic              disp_miss_s, slot_free_s, wr_pend_s, rd_pend_s;
    logic              grant_wr_s, grant_rd_s;
    logic              st_we_s;
    logic [AW-1:0]     st_addr_s;
    logic [STAT_W-1:0] st_wdata_s;

    // Slot arbitration: a display miss owns the slot, otherwise round-robin between game requesters.
    always_comb begin
        disp_addr_s = cell_addr(disp_cell_y, disp_cell_x);
        wr_addr_s   = cell_addr(wr_y, wr_x);
        rd_addr_s   = cell_addr(rd_y, rd_x);
        disp_miss_s = disp_en && (!cache_valid_q || (disp_addr_s != cache_addr_q));
        wr_pend_s   = wr_req && !wr_ack_q;
        rd_pend_s   = rd_req && !rd_ack_q;
        slot_free_s = (state_q == ST_RUN) && !clear_req && !disp_miss_s;
        grant_wr_s  = 1'b0;
        grant_rd_s  = 1'b0;
        if (slot_free_s) begin
            if (wr_pend_s && rd_pend_s) begin
                grant_wr_s = (rr_q == RR_WRITE);
                grant_rd_s = (rr_q == RR_READ);
            end else begin
                grant_wr_s = wr_pend_s;
                grant_rd_s = rd_pend_s;
            end
        end else begin
            grant_wr_s = 1'b0;
            grant_rd_s = 1'b0;
        end
    end

    // Next-state, store write port and registered output values.
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        clr_cnt_d     = clr_cnt_q;
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_data_d  = cache_data_q;
        disp_status_d = disp_status_q;
        rd_data_d     = '0;
        wr_ack_d      = 1'b0;
        rd_ack_d      = 1'b0;
        st_we_s       = 1'b0;
        st_addr_s     = '0;
        st_wdata_s    = '0;
        case (state_q)
            ST_RUN: begin
                if (disp_miss_s) begin
                    disp_status_d = store_q[disp_addr_s];
                    cache_valid_d = 1'b1;
                    cache_addr_d  = disp_addr_s;
                    cache_data_d  = store_q[disp_addr_s];
                end else if (disp_en) begin
                    disp_status_d = cache_data_q;
                end else begin
                    disp_status_d = disp_status_q;
                end
                if (grant_wr_s) begin
                    st_we_s    = 1'b1;
                    st_addr_s  = wr_addr_s;
                    st_wdata_s = wr_data;
                    wr_ack_d   = 1'b1;
                    rr_d       = RR_READ;
                    // Keep the cached pixel coherent with a write to the same cell.
                    if (cache_valid_q && (wr_addr_s == cache_addr_q)) begin
                        cache_data_d  = wr_data;
                        disp_status_d = disp_en ? wr_data : disp_status_q;
                    end else begin
                        cache_data_d  = cache_data_q;
                    end
                end else if (grant_rd_s) begin
                    rd_data_d = store_q[rd_addr_s];
                    rd_ack_d  = 1'b1;
                    rr_d      = RR_WRITE;
                end else begin
                    rr_d = rr_q;
                end
                if (clear_req) begin
                    state_d       = ST_CLEAR;
                    clr_cnt_d     = '0;
                    cache_valid_d = 1'b0;
                    disp_status_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CLEAR: begin
                st_we_s       = 1'b1;
                st_addr_s     = clr_cnt_q;
                st_wdata_s    = '0;
                cache_valid_d = 1'b0;
                disp_status_d = '0;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            default: begin
                state_d       = ST_RUN;
                cache_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Control and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_RUN;
            rr_q          <= RR_WRITE;
            clr_cnt_q     <= '0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
            disp_status_q <= '0;
            rd_data_q     <= '0;
            wr_ack_q      <= 1'b0;
            rd_ack_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            clr_cnt_q     <= clr_cnt_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_data_q  <= cache_data_d;
            disp_status_q <= disp_status_d;
            rd_data_q     <= rd_data_d;
            wr_ack_q      <= wr_ack_d;
            rd_ack_q      <= rd_ack_d;
            busy_q        <= busy_d;
        end
    end

    // Cell-status store, single write port.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= '0;
            end
        end else if (st_we_s) begin
            store_q[st_addr_s] <= st_wdata_s;
        end
    end

    assign disp_status = disp_status_q;
    assign rd_data     = rd_data_q;
    assign wr_ack      = wr_ack_q;
    assign rd_ack      = rd_ack_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_board_status_arbiter.sv
// Randomised and directed bench for board_status_arbiter against a cell-array reference model.
module tb_board_status_arbiter;
    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       disp_en;
    logic [2:0] disp_cell_x, disp_cell_y;
    logic [3:0] disp_status;
    logic       wr_req;
    logic [2:0] wr_x, wr_y;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic       rd_req;
    logic [2:0] rd_x, rd_y;
    logic [3:0] rd_data;
    logic       rd_ack;
    logic       clear_req;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: board contents plus the observable registered outputs.
    int mem [64];
    int last_disp;
    int clear_left;
    bit rr_w;
    int e_disp, e_wr_ack, e_rd_ack, e_rd_data, e_busy;

    board_status_arbiter dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .disp_en(disp_en), .disp_cell_x(disp_cell_x), .disp_cell_y(disp_cell_y),
        .disp_status(disp_status),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_ack(rd_ack),
        .clear_req(clear_req), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mem[i] = 0;
        last_disp  = -1;
        clear_left = 0;
        rr_w       = 1'b1;
        e_disp = 0; e_wr_ack = 0; e_rd_ack = 0; e_rd_data = 0; e_busy = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int da, wa, ra, n_disp, n_rd, n_wa, n_ra;
        bit miss, wp, rp, gw, gr;
        da = int'(disp_cell_y) * 8 + int'(disp_cell_x);
        wa = int'(wr_y) * 8 + int'(wr_x);
        ra = int'(rd_y) * 8 + int'(rd_x);
        n_disp = e_disp; n_rd = e_rd_data; n_wa = 0; n_ra = 0;
        if (clear_left > 0) begin
            clear_left--;
            n_disp = 0;
        end else if (clear_req) begin
            for (int i = 0; i < 64; i++) mem[i] = 0;
            clear_left = 64;
            last_disp  = -1;
            n_disp     = 0;
        end else begin
            miss = disp_en && (da != last_disp);
            wp   = wr_req && (e_wr_ack == 0);
            rp   = rd_req && (e_rd_ack == 0);
            gw   = !miss && wp && (rr_w || !rp);
            gr   = !miss && rp && !gw;
            if (gw) begin mem[wa] = int'(wr_data); rr_w = 1'b0; n_wa = 1; end
            if (gr) begin n_rd = mem[ra]; rr_w = 1'b1; n_ra = 1; end
            if (disp_en) begin n_disp = mem[da]; last_disp = da; end
        end
        e_disp = n_disp; e_wr_ack = n_wa; e_rd_ack = n_ra; e_rd_data = n_rd;
        e_busy = (clear_left > 0) ? 1 : 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk_in);
        #1;
        chk("disp_status", 32'(disp_status), e_disp);
        chk("wr_ack", 32'(wr_ack), e_wr_ack);
        chk("rd_ack", 32'(rd_ack), e_rd_ack);
        chk("busy", 32'(busy), e_busy);
        if (e_rd_ack != 0) chk("rd_data", 32'(rd_data), e_rd_data);
    endtask

    task automatic drop_acked();
        if (wr_req && e_wr_ack != 0) wr_req = 1'b0;
        if (rd_req && e_rd_ack != 0) rd_req = 1'b0;
    endtask

    task automatic write_cell(input int x, input int y, input int d);
        wr_x = 3'(x); wr_y = 3'(y); wr_data = 4'(d); wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        step();
    endtask

    initial begin
        int busy_cnt;
        rst_n_in = 1'b0; disp_en = 1'b0; disp_cell_x = 3'd0; disp_cell_y = 3'd0;
        wr_req = 1'b0; wr_x = 3'd0; wr_y = 3'd0; wr_data = 4'd0;
        rd_req = 1'b0; rd_x = 3'd0; rd_y = 3'd0; clear_req = 1'b0;
        model_reset();
        #1;
        chk("rst_disp", 32'(disp_status), 0);
        chk("rst_acks", 32'({wr_ack, rd_ack}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;

        // Sweep row 0 after reset: every cell shows 0.
        disp_en = 1'b1;
        for (int x = 0; x < 8; x++) begin
            disp_cell_x = 3'(x);
            step();
            chk("t1_disp", 32'(disp_status), 0);
            step();
        end

        // Write (3,2)=9 during blanking, then display it.
        disp_en = 1'b0;
        wr_x = 3'd3; wr_y = 3'd2; wr_data = 4'd9; wr_req = 1'b1;
        step();
        chk("t2_wr_ack", 32'(wr_ack), 1);
        wr_req = 1'b0;
        disp_en = 1'b1; disp_cell_x = 3'd3; disp_cell_y = 3'd2;
        step();
        chk("t2_disp", 32'(disp_status), 9);

        // Parked on (5,5), write 7 into it: the pixel follows the write.
        disp_cell_x = 3'd5; disp_cell_y = 3'd5;
        step(); step();
        wr_x = 3'd5; wr_y = 3'd5; wr_data = 4'd7; wr_req = 1'b1;
        step();
        chk("t3_wr_ack", 32'(wr_ack), 1);
        chk("t3_disp", 32'(disp_status), 7);
        wr_req = 1'b0;
        step();
        rd_x = 3'd5; rd_y = 3'd5; rd_req = 1'b1;
        step();
        chk("t3_rd_ack", 32'(rd_ack), 1);
        chk("t3_rd_data", 32'(rd_data), 7);
        rd_req = 1'b0;
        step();

        // Both requesters held: grants alternate W,R,W,R.
        disp_en = 1'b0;
        wr_x = 3'd1; wr_y = 3'd1; wr_data = 4'd5; wr_req = 1'b1;
        rd_x = 3'd1; rd_y = 3'd1; rd_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            step();
            chk("t4_wr_order", 32'(wr_ack), (g % 2 == 0) ? 1 : 0);
            chk("t4_rd_order", 32'(rd_ack), (g % 2 == 1) ? 1 : 0);
            if (g % 2 == 1) chk("t4_rd_data", 32'(rd_data), 5);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        step();

        // Display misses every cycle hold off a pending read until a blanking cycle.
        disp_en = 1'b1; disp_cell_y = 3'd0;
        rd_x = 3'd5; rd_y = 3'd5; rd_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            disp_cell_x = 3'(k % 2);
            step();
            chk("t5_no_ack", 32'(rd_ack), 0);
        end
        disp_en = 1'b0;
        step();
        chk("t5_rd_ack", 32'(rd_ack), 1);
        chk("t5_rd_data", 32'(rd_data), 7);
        rd_req = 1'b0;
        step();

        // Randomised traffic, including occasional clears.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 9) == 0) disp_en = ~disp_en;
            if ($urandom_range(0, 3) == 0) begin
                disp_cell_x = 3'($urandom_range(0, 7));
                disp_cell_y = 3'($urandom_range(0, 7));
            end
            if (!wr_req && e_wr_ack == 0 && $urandom_range(0, 2) == 0) begin
                wr_x = 3'($urandom_range(0, 7)); wr_y = 3'($urandom_range(0, 7));
                wr_data = 4'($urandom_range(0, 15)); wr_req = 1'b1;
            end
            if (!rd_req && e_rd_ack == 0 && $urandom_range(0, 2) == 0) begin
                rd_x = 3'($urandom_range(0, 7)); rd_y = 3'($urandom_range(0, 7));
                rd_req = 1'b1;
            end
            clear_req = ($urandom_range(0, 249) == 0);
            step();
            clear_req = 1'b0;
            drop_acked();
        end
        for (int k = 0; k < 80; k++) begin
            wr_req = wr_req && (e_wr_ack == 0);
            step();
            drop_acked();
        end
        wr_req = 1'b0; rd_req = 1'b0;
        step();

        // Fill the board with 0xF, then CLEAR with requests held pending.
        disp_en = 1'b0;
        for (int a = 0; a < 64; a++) write_cell(a % 8, a / 8, 15);
        disp_en = 1'b1; disp_cell_x = 3'd2; disp_cell_y = 3'd2;
        step(); step();
        chk("t6_fill_disp", 32'(disp_status), 15);
        disp_en = 1'b0;
        clear_req = 1'b1;
        wr_x = 3'd4; wr_y = 3'd4; wr_data = 4'd0; wr_req = 1'b1;
        rd_x = 3'd4; rd_y = 3'd4; rd_req = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 72; k++) begin
            step();
            clear_req = 1'b0;
            if (busy) begin
                busy_cnt++;
                chk("t6_no_ack", 32'({wr_ack, rd_ack}), 0);
            end
            drop_acked();
        end
        chk("t6_busy_len", busy_cnt, 64);
        wr_req = 1'b0; rd_req = 1'b0;
        for (int a = 0; a < 64; a++) begin
            rd_x = 3'(a % 8); rd_y = 3'(a / 8); rd_req = 1'b1;
            step();
            chk("t6_clr_ack", 32'(rd_ack), 1);
            chk("t6_clr_data", 32'(rd_data), 0);
            rd_req = 1'b0;
            step();
        end

        // Second CLEAR aborted by reset at busy cycle 30; the last cell is not yet swept.
        write_cell(7, 7, 15);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (29) step();
        chk("t6_busy30", 32'(busy), 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("t6_rst_disp", 32'(disp_status), 0);
        chk("t6_rst_acks", 32'({wr_ack, rd_ack}), 0);
        chk("t6_rst_rd_data", 32'(rd_data), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        model_reset();
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        rd_x = 3'd7; rd_y = 3'd7; rd_req = 1'b1;
        step();
        chk("t6_rst_store", 32'(rd_data), 0);
        rd_req = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
